mc_sequencer: RTL
=================

Name: mc_sequencer

Overview:
- Multi-cycle control sequencer for the RV64 integer core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the instruction-bus and data-bus handshakes and gates the decoder's raw strobes (register-file write, data-memory read/write) into single-cycle enables.
- Sits between the instruction decoder, the PC/IR registers and the two memory buses; a bus that never responds ends in a sticky error.

Parameters:
- TO_W, 8, width of the bus-wait timeout counter.
- TO_MAX, 200, wait cycles allowed in IWAIT/MWAIT before entering ERR (must be < 2^TO_W).

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  when low, no new fetch is issued; the instruction in flight completes.
- ibus_req  out  1  instruction fetch request; held until granted.
- ibus_gnt  in  1  instruction bus accepts the request this cycle.
- ibus_rvalid  in  1  instruction word valid this cycle.
- dbus_req  out  1  data access request; held until granted.
- dbus_we  out  1  data access is a write (valid while dbus_req=1).
- dbus_gnt  in  1  data bus accepts the request this cycle.
- dbus_rvalid  in  1  load data valid, or store acknowledged.
- dec_rf_w  in  1  decoder register-write strobe.
- dec_dm_r  in  1  decoder load strobe.
- dec_dm_w  in  1  decoder store strobe.
- ir_we  out  1  capture the instruction word into IR.
- pc_we  out  1  update PC from the next-PC mux.
- rf_we  out  1  gated register-file write enable.
- ld_we  out  1  capture load data into the MDR.
- retire  out  1  one-cycle pulse per completed instruction.
- err  out  1  sticky bus-timeout error.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, IWAIT=1, DECODE=2, EXEC=3, MEM=4, MWAIT=5, WB=6, ERR=7.
- Reset (async, rst_n=0):
  - State goes to FETCH.
  - All outputs are 0: ibus_req, dbus_req, dbus_we, ir_we, pc_we, rf_we, ld_we, retire, err.
  - Timeout counter clears.
  - A reset in the middle of a bus transaction abandons it; no pulse is emitted.
- FETCH:
  - ibus_req = run.
  - If run && ibus_gnt, go to IWAIT.
  - If run=0, stay in FETCH with ibus_req=0.
- IWAIT:
  - ibus_req = 0. Counter increments each cycle.
  - On ibus_rvalid: ir_we=1 for that cycle, counter clears, go to DECODE.
  - If ibus_rvalid and counter==TO_MAX occur in the same cycle, rvalid wins.
  - On counter==TO_MAX without rvalid, go to ERR.
- DECODE: one cycle; decoder inputs settle from IR. Go to EXEC.
- EXEC:
  - One cycle; dec_dm_r/dec_dm_w are registered here.
  - If either is set, go to MEM; otherwise go to WB.
  - If both are set, it is treated as a store.
- MEM:
  - dbus_req=1; dbus_we = registered store flag.
  - Stay until dbus_gnt, then go to MWAIT.
- MWAIT:
  - Same timeout rule as IWAIT.
  - On dbus_rvalid: ld_we=1 if the access is a load; go to WB.
- WB:
  - One cycle.
  - rf_we = dec_rf_w && !store (stores never write the register file).
  - pc_we=1 and retire=1.
  - Next state is FETCH.
- ERR: all strobes 0, err=1. State is absorbing; only reset exits.
- Pulse rules:
  - ir_we, ld_we, pc_we, rf_we and retire are each exactly 1 cycle wide, at most once per instruction.
  - Requests are level signals and drop in the cycle after the grant.
- Ungranted requests: a gnt or rvalid seen in a state not waiting for it is ignored.
- Latency with zero-wait buses (gnt same cycle, rvalid next cycle):
  - ALU/jump instruction: 5 cycles, FETCH to WB inclusive.
  - Load or store: 7 cycles.
- Timeout counter: saturating, TO_W bits. It runs only in IWAIT/MWAIT and clears on entry to either.

Optional Feature:
- Macro: MC_SEQ_PERF_EN.
- When defined, two extra ports are added:
  - cyc_cnt  out  64: increments every cycle outside ERR.
  - ret_cnt  out  64: increments on retire.
  - Both reset to 0 and wrap modulo 2^64.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Zero-wait ADD, dec_rf_w=1: state_o sequence 0,1,2,3,6,0; ir_we at cycle 2, rf_we/pc_we/retire at cycle 5, total 5 cycles.
- Load with gnt delayed 3 cycles and rvalid 2 cycles later: dbus_req high 4 cycles, dbus_we=0, ld_we 1 pulse, rf_we in WB, 11 cycles total.
- Store with dec_rf_w=1: dbus_we=1 during MEM, rf_we stays 0 in WB, retire=1.
- TO_MAX=4, ibus_rvalid never asserted: ERR entered 4 cycles after IWAIT entry; err=1, ibus_req=0, held for 20 cycles.
- run=0 during an ADD in EXEC: the instruction retires, then FETCH holds with ibus_req=0; run=1 restarts fetch next cycle.
- rst_n pulled low mid-MWAIT: outputs 0 immediately (async), state_o=0; no ld_we/retire; a normal fetch follows release.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the RV64 integer core.
// Steps each instruction through FETCH, IWAIT, DECODE, EXEC, [MEM, MWAIT,] WB.
// It drives the instruction and data bus handshakes and turns the decoder's raw
// strobes into single-cycle enables. A bus that does not respond within TO_MAX
// wait cycles sends the sequencer to an absorbing ERR state.
//
// Ports:
//   clk, rst_n                 core clock (rising edge), async active-low reset
//   run                        low: no new fetch; the instruction in flight completes
//   ibus_req/gnt/rvalid        instruction bus handshake
//   dbus_req/we/gnt/rvalid     data bus handshake (dbus_we valid while dbus_req=1)
//   dec_rf_w/dm_r/dm_w         raw decoder strobes
//   ir_we, pc_we, rf_we, ld_we single-cycle enables for IR, PC, register file, MDR
//   retire                     one pulse per completed instruction
//   err                        sticky bus-timeout error
//   state_o                    current state encoding, for debug
//
// Optional feature, enabled by defining MC_SEQ_PERF_EN:
//   cyc_cnt  64-bit count of cycles spent outside ERR
//   ret_cnt  64-bit count of retired instructions
module mc_sequencer #(
  parameter int unsigned TO_W   = 8,
  parameter int unsigned TO_MAX = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        ibus_req,
  input  logic        ibus_gnt,
  input  logic        ibus_rvalid,
  output logic        dbus_req,
  output logic        dbus_we,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic        dec_rf_w,
  input  logic        dec_dm_r,
  input  logic        dec_dm_w,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        ld_we,
  output logic        retire,
  output logic        err,
`ifdef MC_SEQ_PERF_EN
  output logic [63:0] cyc_cnt,
  output logic [63:0] ret_cnt,
`endif
  output logic [2:0]  state_o
);

  localparam logic [2:0] StFetch  = 3'd0;
  localparam logic [2:0] StIwait  = 3'd1;
  localparam logic [2:0] StDecode = 3'd2;
  localparam logic [2:0] StExec   = 3'd3;
  localparam logic [2:0] StMem    = 3'd4;
  localparam logic [2:0] StMwait  = 3'd5;
  localparam logic [2:0] StWb     = 3'd6;
  localparam logic [2:0] StErr    = 3'd7;

  // The counter holds the number of wait cycles already elapsed; when it holds
  // TO_MAX-1 the current cycle is the last one allowed.
  localparam logic [TO_W-1:0] ToLast = TO_W'(TO_MAX - 1);

  logic [2:0]      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            store_q, store_d;
  logic            load_q, load_d;
  logic [TO_W-1:0] cnt_inc;

  // Saturating increment.
  assign cnt_inc = (cnt_q == {TO_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    store_d  = store_q;
    load_d   = load_q;
    ibus_req = 1'b0;
    dbus_req = 1'b0;
    dbus_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    ld_we    = 1'b0;
    retire   = 1'b0;
    err      = 1'b0;
    case (state_q)
      StFetch: begin
        // Qualified by rst_n so the request is low while reset is held.
        ibus_req = run & rst_n;
        if (run && ibus_gnt) state_d = StIwait;
      end
      StIwait: begin
        if (ibus_rvalid) begin
          ir_we   = 1'b1;
          state_d = StDecode;
        end else if (cnt_q == ToLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        // Both strobes set is treated as a store.
        store_d = dec_dm_w;
        load_d  = dec_dm_r & ~dec_dm_w;
        state_d = (dec_dm_r || dec_dm_w) ? StMem : StWb;
      end
      StMem: begin
        dbus_req = 1'b1;
        dbus_we  = store_q;
        if (dbus_gnt) state_d = StMwait;
      end
      StMwait: begin
        if (dbus_rvalid) begin
          ld_we   = load_q;
          state_d = StWb;
        end else if (cnt_q == ToLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWb: begin
        rf_we   = dec_rf_w & ~store_q;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StErr: err = 1'b1;
      default: state_d = StErr;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cnt_q   <= '0;
      store_q <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      store_q <= store_d;
      load_q  <= load_d;
    end
  end

  assign state_o = state_q;

`ifdef MC_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      if (state_q != StErr) cyc_cnt <= cyc_cnt + 64'd1;
      if (retire)           ret_cnt <= ret_cnt + 64'd1;
    end
  end
`endif

endmodule
